button_conditioner: RTL

//  Converts a raw, bouncing, active-low push-button into clean signals for the

---
 rtl/button_conditioner.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Debounces a raw active-low push-button into a clean level plus one-cycle press/release pulses.
// The accepted-release pulse is on port release_o because "release" is a reserved word.
// Optional feature: define AUTO_REPEAT_EN to re-issue press pulses while the button is held.
module button_conditioner #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_RATE     = 24'd1000000
) (
  input  logic clk,
  input  logic rstN,
  input  logic btnN,
  output logic level,
  output logic press,
  output logic release_o
);

  localparam int CNT_W = $clog2(int'(DEBOUNCE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             btn_meta_q;
  logic             btn_s_q;

`ifdef AUTO_REPEAT_EN
  localparam logic [23:0] RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W = $clog2(int'(RPT_MAX) + 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 24'd1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 24'd1);
  localparam logic [RCNT_W-1:0] RCNT_MAX   = {RCNT_W{1'b1}};

  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              rpt_later_q, rpt_later_d;
  logic [RCNT_W-1:0] rpt_thresh_s;

  assign rpt_thresh_s = rpt_later_q ? RATE_LAST : DELAY_LAST;
`endif

  // Two-flop synchroniser; resets to the released (high) level.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      btn_meta_q <= 1'b1;
      btn_s_q    <= 1'b1;
    end else begin
      btn_meta_q <= btnN;
      btn_s_q    <= btn_meta_q;
    end
  end

  // Debounce FSM next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef AUTO_REPEAT_EN
    rcnt_d      = rcnt_q;
    rpt_later_d = rpt_later_q;
`endif
    case (state_q)
      IDLE: begin
        if (!btn_s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (btn_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b0;
          press_d = 1'b1;
`ifdef AUTO_REPEAT_EN
          rcnt_d      = '0;
          rpt_later_d = 1'b0;
`endif
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (btn_s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
`ifdef AUTO_REPEAT_EN
          // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE.
          if (rcnt_q == rpt_thresh_s) begin
            press_d     = 1'b1;
            rcnt_d      = '0;
            rpt_later_d = 1'b1;
          end else begin
            rcnt_d = (rcnt_q == RCNT_MAX) ? rcnt_q : rcnt_q + RCNT_W'(1);
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (!btn_s_q) begin
          // Bounce back to HELD keeps the repeat timer running.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b1;
          release_d = 1'b1;
`ifdef AUTO_REPEAT_EN
          rcnt_d      = '0;
          rpt_later_d = 1'b0;
`endif
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b1;
      end
    endcase
  end

  // FSM state, counters and output registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  // Auto-repeat timer and first/later threshold flag.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rcnt_q      <= '0;
      rpt_later_q <= 1'b0;
    end else begin
      rcnt_q      <= rcnt_d;
      rpt_later_q <= rpt_later_d;
    end
  end
`endif

  assign level     = level_q;
  assign press     = press_q;
  assign release_o = release_q;

endmodule
